rose_stim_driver: RTL and testbench

- Stimulus-and-scoreboard block for the team's $rose sampled-value checker (ports signal_in, en, match, fail).
- Takes a PAT_W-bit signal pattern and a per-cycle enable mask.
- Drives the pattern serially into the checker.
- Computes the expected match/fail for every evaluation cycle, compares it against the checker's outputs, and accumulates error and hit counts.
- Sits in the assertion-RTL self-test harness, one instance per checker under test.

---
 rtl/rose_stim_driver.sv | 185 ++++++++++++++++++
 tb/tb_rose_stim_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rose_stim_driver.sv
// Drives a latched signal/enable pattern into a $rose checker and scores its match/fail outputs.
// Optional: define ROSE_STIM_FELL_MODE_EN to add a fell_mode input ($fell expectations).
module rose_stim_driver #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] en_mask,
`ifdef ROSE_STIM_FELL_MODE_EN
  input  logic             fell_mode,
`endif
  input  logic             match_in,
  input  logic             fail_in,
  output logic             sig_out,
  output logic             en_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drain_q, drain_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] msk_q, msk_d;
  logic             sig_q, sig_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clr_cnt;
  logic             cmp_vld_q, cmp_vld_d;
  logic             prev_s_q, prev_e_q;
  logic             exp_m_q, exp_m_d;
  logic             exp_f_q, exp_f_d;
  logic             edge_k;
  logic             miscmp;
  logic             hit;
  logic             mism_q;
  logic [CNT_W-1:0] err_q, hit_q;
`ifdef ROSE_STIM_FELL_MODE_EN
  logic             fell_q, fell_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    pat_d   = pat_q;
    msk_d   = msk_q;
    sig_d   = 1'b0;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    clr_cnt = 1'b0;
`ifdef ROSE_STIM_FELL_MODE_EN
    fell_d  = fell_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Bit 0 goes straight to the output register; the rest shifts down one per RUN cycle.
          state_d = S_RUN;
          idx_d   = '0;
          pat_d   = pattern >> 1;
          msk_d   = en_mask >> 1;
          sig_d   = pattern[0];
          en_d    = en_mask[0];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          clr_cnt = 1'b1;
`ifdef ROSE_STIM_FELL_MODE_EN
          fell_d  = fell_mode;
`endif
        end
      end
      S_RUN: begin
        // On the last RUN cycle the shifted-in zeros give the 0/0 drive of the first DRAIN cycle.
        sig_d = pat_q[0];
        en_d  = msk_q[0];
        pat_d = pat_q >> 1;
        msk_d = msk_q >> 1;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          idx_d   = '0;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The expectation for drive cycle k is formed at its closing edge and compared in cycle k+1.
`ifdef ROSE_STIM_FELL_MODE_EN
  assign edge_k = fell_q ? (~sig_q & prev_s_q) : (sig_q & ~prev_s_q);
`else
  assign edge_k = sig_q & ~prev_s_q;
`endif
  assign exp_m_d   = prev_e_q & edge_k;
  assign exp_f_d   = prev_e_q & ~edge_k;
  assign cmp_vld_d = (state_q == S_RUN) || ((state_q == S_DRAIN) && !drain_q);
  assign miscmp    = cmp_vld_q && ({match_in, fail_in} != {exp_m_q, exp_f_q});
  assign hit       = cmp_vld_q && exp_m_q && match_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      drain_q   <= 1'b0;
      pat_q     <= '0;
      msk_q     <= '0;
      sig_q     <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      prev_s_q  <= 1'b0;
      prev_e_q  <= 1'b0;
      exp_m_q   <= 1'b0;
      exp_f_q   <= 1'b0;
      mism_q    <= 1'b0;
      err_q     <= '0;
      hit_q     <= '0;
`ifdef ROSE_STIM_FELL_MODE_EN
      fell_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      pat_q     <= pat_d;
      msk_q     <= msk_d;
      sig_q     <= sig_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmp_vld_q <= cmp_vld_d;
      prev_s_q  <= sig_q;
      prev_e_q  <= en_q;
      exp_m_q   <= exp_m_d;
      exp_f_q   <= exp_f_d;
      mism_q    <= miscmp;
`ifdef ROSE_STIM_FELL_MODE_EN
      fell_q    <= fell_d;
`endif
      if (clr_cnt) begin
        err_q <= '0;
        hit_q <= '0;
      end else begin
        if (miscmp && (err_q != CNT_MAX)) err_q <= err_q + CNT_W'(1);
        if (hit && (hit_q != CNT_MAX))    hit_q <= hit_q + CNT_W'(1);
      end
    end
  end

  assign sig_out   = sig_q;
  assign en_out    = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mismatch  = mism_q;
  assign err_cnt   = err_q;
  assign hit_cnt   = hit_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rose_stim_driver.sv
// Directed bench for rose_stim_driver: an ideal $rose checker model closes the loop,
// with per-cycle output override for fault injection, plus a CNT_W=2 saturation instance.
module tb_rose_stim_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [15:0] en_mask = '0;
  logic        inj = 1'b0;
  logic [1:0]  inj_val = 2'b00;

  logic        sig_out, en_out, busy, done, mismatch;
  logic [7:0]  err_cnt, hit_cnt;
  logic [1:0]  dbg_state;
  logic        match_in, fail_in;

  logic        s_sig_out, s_en_out, s_busy, s_done, s_mismatch;
  logic [1:0]  s_err_cnt, s_hit_cnt, s_dbg_state;

  logic        chk_s_q, chk_e_q, chk_match, chk_fail;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Ideal $rose checker: in cycle k+1 reports s[k-1]->s[k] qualified by e[k-1].
  always @(posedge clk) begin
    if (!rst_n) begin
      chk_s_q <= 1'b0; chk_e_q <= 1'b0; chk_match <= 1'b0; chk_fail <= 1'b0;
    end else begin
      chk_s_q   <= sig_out;
      chk_e_q   <= en_out;
      chk_match <= chk_e_q & sig_out & ~chk_s_q;
      chk_fail  <= chk_e_q & ~(sig_out & ~chk_s_q);
    end
  end

  assign match_in = inj ? inj_val[1] : chk_match;
  assign fail_in  = inj ? inj_val[0] : chk_fail;

  rose_stim_driver #(.PAT_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .en_mask(en_mask),
`ifdef ROSE_STIM_FELL_MODE_EN
    .fell_mode(1'b0),
`endif
    .match_in(match_in), .fail_in(fail_in),
    .sig_out(sig_out), .en_out(en_out), .busy(busy), .done(done), .mismatch(mismatch),
    .err_cnt(err_cnt), .hit_cnt(hit_cnt), .dbg_state(dbg_state)
  );

  // Checker inputs tied low so every enabled cycle miscompares.
  rose_stim_driver #(.PAT_W(16), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .en_mask(en_mask),
`ifdef ROSE_STIM_FELL_MODE_EN
    .fell_mode(1'b0),
`endif
    .match_in(1'b0), .fail_in(1'b0),
    .sig_out(s_sig_out), .en_out(s_en_out), .busy(s_busy), .done(s_done), .mismatch(s_mismatch),
    .err_cnt(s_err_cnt), .hit_cnt(s_hit_cnt), .dbg_state(s_dbg_state)
  );

  typedef struct {
    logic [15:0] pat;
    logic [15:0] msk;
    int          inj_c;
    logic [1:0]  inj_v;
    int          glitch_c;
    int          exp_err;
    int          exp_hit;
    int          exp_pulses;
    logic        exp_mad;
    int          exp_sat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sig"}, sig_out, 0);
    check({tag, "_en"}, en_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mism"}, mismatch, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_hit"}, hit_cnt, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Called at #1 after a posedge; start edge is the next posedge, cycle 0 follows it.
  task automatic run_vec(input vec_t v, input string tag);
    int   c;
    int   pulses;
    int   done_cyc;
    logic mad;
    pattern = v.pat;
    en_mask = v.msk;
    start   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    c        = 0;
    pulses   = 0;
    done_cyc = -1;
    mad      = 1'b0;
    while (c < 60) begin
      inj     = (c == v.inj_c);
      inj_val = v.inj_v;
      start   = (c == v.glitch_c);
      pattern = (c == v.glitch_c) ? ~v.pat : v.pat;
      en_mask = (c == v.glitch_c) ? ~v.msk : v.msk;
      if (mismatch) pulses++;
      if (done) begin
        done_cyc = c;
        mad      = mismatch;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    inj   = 1'b0;
    start = 1'b0;
    check({tag, "_run_len"}, done_cyc, 18);
    check({tag, "_err_cnt"}, err_cnt, v.exp_err);
    check({tag, "_hit_cnt"}, hit_cnt, v.exp_hit);
    check({tag, "_pulses"}, pulses, v.exp_pulses);
    check({tag, "_mism_at_done"}, mad, v.exp_mad);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_state_done"}, dbg_state, 3);
    if (v.exp_sat >= 0) check({tag, "_sat_err"}, s_err_cnt, v.exp_sat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t clean;
    vecs[0] = '{16'h0002, 16'hFFFF, -1, 2'b00, -1, 0, 1, 0, 1'b0, -1};
    vecs[1] = '{16'h5555, 16'h0000, -1, 2'b00, -1, 0, 0, 0, 1'b0, -1};
    vecs[2] = '{16'h00F0, 16'hFFFF,  5, 2'b01, -1, 1, 0, 1, 1'b0, -1};
    vecs[3] = '{16'hAAAA, 16'hFFFF, -1, 2'b00, -1, 0, 8, 0, 1'b0,  3};
    vecs[4] = '{16'h0001, 16'hFFFF, -1, 2'b00, -1, 0, 0, 0, 1'b0, -1};
    vecs[5] = '{16'h8000, 16'hFFFF, 17, 2'b00, -1, 1, 1, 1, 1'b1, -1};
    vecs[6] = '{16'h0F0F, 16'hF0F0, -1, 2'b00, -1, 0, 1, 0, 1'b0, -1};
    vecs[7] = '{16'h0002, 16'hFFFF, -1, 2'b00,  3, 0, 1, 0, 1'b0, -1};

    // Clock/reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_hold_state", dbg_state, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start in DONE restarts straight into RUN.
    pattern = 16'h0002;
    en_mask = 16'hFFFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_done_cleared", done, 0);
    check("restart_busy", busy, 1);
    check("restart_state_run", dbg_state, 1);
    check("restart_err_cleared", err_cnt, 0);

    // Reset asserted during drive cycle 5.
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midrun_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    clean = vecs[0];
    run_vec(clean, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
